// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared segment patterns, anode constants and digit-index type for the scan driver.
package seven_seg_pkg;
  localparam int IDX_W = 2;
  typedef logic [IDX_W-1:0] idx_t;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [3:0] AN_OFF   = 4'b1111;
endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD to active-low gfedcba decoder; codes above 9 show a dash.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode scan driver with per-frame snapshot and leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int DIGIT_HZ      = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] thos,
  input  logic [3:0] hund,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] dp_in,
  input  logic       en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);
  localparam int DIV = CLK_HZ / DIGIT_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  if (DIV < 2) begin : g_div_chk
    $error("seven_seg_scan: CLK_HZ/DIGIT_HZ must be at least 2");
  end
  logic [PW-1:0]   r_pre;
  idx_t            r_idx;
  logic [3:0][3:0] r_dig;
  logic [3:0]      r_dpm;
  logic            w_tick;
  logic            w_off;
  logic [3:0]      w_lead;
  logic [6:0]      w_seg;
  assign w_tick = r_pre == PW'(DIV - 1);
  // w_lead[i]: digit i and every digit above it are zero; the ones digit is never leading
  assign w_lead = {r_dig[3] == '0, r_dig[3:2] == '0, r_dig[3:1] == '0, 1'b0};
  assign w_off  = !en || (BLANK_LEADING && w_lead[r_idx]);
  bcd_to_seg u_dec (
    .i_bcd(r_dig[r_idx]),
    .o_seg(w_seg)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre       <= '0;
      r_idx       <= '0;
      r_dig       <= '0;
      r_dpm       <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      r_pre       <= w_tick ? '0 : r_pre + 1'b1;
      r_idx       <= r_idx + idx_t'(w_tick);
      frame_start <= w_tick && r_idx == '1;
      if (w_tick && r_idx == '1) begin
        r_dig <= {thos, hund, tens, ones};
        r_dpm <= dp_in;
      end
      an          <= w_off ? AN_OFF : ~(4'b0001 << r_idx);
      seg         <= w_off ? SEG_OFF : w_seg;
      dp          <= w_off || !r_dpm[r_idx];
    end
  end
endmodule
